dma_bus_master: RTL and testbench

//  Word-copy DMA engine: the initiator for the single-cycle peripheral bus
//  (we/addr/wdata, combinational rdata) that memory-mapped slaves respond on.
//  CPU programs SRC/DST/LEN through a slave config port at `BASE_DMA0.

---
 rtl/dma_pkg.sv | 28 ++
 rtl/dma_cfg_regs.sv | 86 ++++++++
 rtl/dma_bus_master.sv | 118 +++++++++++
 tb/tb_dma_bus_master.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// DMA engine shared definitions.
// Register offsets, bit positions and FSM state encoding.
package dma_pkg;

    localparam logic [31:0] BASE_DMA0 = 32'h1000_0000;

    localparam logic [31:0] OFF_CTRL = 32'h00;
    localparam logic [31:0] OFF_STAT = 32'h04;
    localparam logic [31:0] OFF_SRC  = 32'h08;
    localparam logic [31:0] OFF_DST  = 32'h0C;
    localparam logic [31:0] OFF_LEN  = 32'h10;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ABORT  = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } dma_state_e;

endpackage

// File: rtl/dma_cfg_regs.sv
// DMA config slave: address decode, register file, W1P/W1C handling.
// Programmed SRC/DST/LEN are frozen while the engine is busy.
module dma_cfg_regs
    import dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_cfg_we,
    input  logic [31:0]      i_cfg_addr,
    input  logic [31:0]      i_cfg_wdata,
    output logic [31:0]      o_cfg_rdata,
    input  logic             i_busy,
    input  logic             i_done_set,
    output logic             o_start,
    output logic             o_abort,
    output logic             o_irq_en,
    output logic             o_done,
    output logic [31:0]      o_src,
    output logic [31:0]      o_dst,
    output logic [LEN_W-1:0] o_len
);

    logic sel_ctrl, sel_stat, sel_src, sel_dst, sel_len;
    logic wr_ctrl, wr_stat, wr_prog;
    logic aborted;

    assign sel_ctrl = (i_cfg_addr == BASE_DMA0 + OFF_CTRL);
    assign sel_stat = (i_cfg_addr == BASE_DMA0 + OFF_STAT);
    assign sel_src  = (i_cfg_addr == BASE_DMA0 + OFF_SRC);
    assign sel_dst  = (i_cfg_addr == BASE_DMA0 + OFF_DST);
    assign sel_len  = (i_cfg_addr == BASE_DMA0 + OFF_LEN);

    assign wr_ctrl = i_cfg_we & sel_ctrl;
    assign wr_stat = i_cfg_we & sel_stat;
    assign wr_prog = i_cfg_we & ~i_busy;

    // abort beats start when both land in one write
    assign o_abort = wr_ctrl & i_cfg_wdata[CTRL_ABORT];
    assign o_start = wr_ctrl & i_cfg_wdata[CTRL_START]
                   & ~i_cfg_wdata[CTRL_ABORT] & ~i_busy;

    // register file with sticky status; hardware set beats W1C
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_irq_en <= 1'b0;
            o_done   <= 1'b0;
            aborted  <= 1'b0;
            o_src    <= '0;
            o_dst    <= '0;
            o_len    <= '0;
        end else begin
            if (wr_ctrl)
                o_irq_en <= i_cfg_wdata[CTRL_IRQ_EN];
            if (i_done_set)
                o_done <= 1'b1;
            else if (wr_stat && i_cfg_wdata[STAT_DONE])
                o_done <= 1'b0;
            if (o_abort && i_busy)
                aborted <= 1'b1;
            else if (wr_stat && i_cfg_wdata[STAT_ABORTED])
                aborted <= 1'b0;
            if (wr_prog && sel_src)
                o_src <= {i_cfg_wdata[31:2], 2'b00};
            if (wr_prog && sel_dst)
                o_dst <= {i_cfg_wdata[31:2], 2'b00};
            if (wr_prog && sel_len)
                o_len <= i_cfg_wdata[LEN_W-1:0];
        end
    end

    // combinational readback, zero for unmapped offsets
    always_comb begin
        o_cfg_rdata = '0;
        unique case (1'b1)
            sel_ctrl: o_cfg_rdata = {30'd0, o_irq_en, 1'b0};
            sel_stat: o_cfg_rdata = {29'd0, aborted, o_done, i_busy};
            sel_src:  o_cfg_rdata = o_src;
            sel_dst:  o_cfg_rdata = o_dst;
            sel_len:  o_cfg_rdata = 32'(o_len);
            default:  o_cfg_rdata = '0;
        endcase
    end

endmodule

// File: rtl/dma_bus_master.sv
// Word-copy DMA engine: read/write beat FSM on the peripheral bus.
// Config registers live in dma_cfg_regs; this file owns the copy loop.
module dma_bus_master
    import dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_cfg_we,
    input  logic [31:0] i_cfg_addr,
    input  logic [31:0] i_cfg_wdata,
    output logic [31:0] o_cfg_rdata,
    output logic        o_req,
    input  logic        i_gnt,
    output logic        o_m_we,
    output logic [31:0] o_m_addr,
    output logic [31:0] o_m_wdata,
    input  logic [31:0] i_m_rdata,
    output logic        o_irq
);

    dma_state_e state, state_nx;

    logic [31:0]      src_cur, dst_cur, data_buf;
    logic [LEN_W-1:0] cnt;
    logic [31:0]      src_reg, dst_reg;
    logic [LEN_W-1:0] len_reg;
    logic             start, abort, irq_en, done;
    logic             busy, done_set, beat;

    assign busy     = (state != IDLE);
    assign done_set = (state == DONE) & ~abort;
    assign beat     = o_req & i_gnt & ~abort;
    assign o_irq    = done & irq_en;

    dma_cfg_regs #(.LEN_W(LEN_W)) u_cfg (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_addr  (i_cfg_addr),
        .i_cfg_wdata (i_cfg_wdata),
        .o_cfg_rdata (o_cfg_rdata),
        .i_busy      (busy),
        .i_done_set  (done_set),
        .o_start     (start),
        .o_abort     (abort),
        .o_irq_en    (irq_en),
        .o_done      (done),
        .o_src       (src_reg),
        .o_dst       (dst_reg),
        .o_len       (len_reg)
    );

    // state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next state and bus outputs; abort leaves any busy state
    always_comb begin
        state_nx  = state;
        o_req     = 1'b0;
        o_m_we    = 1'b0;
        o_m_addr  = '0;
        o_m_wdata = '0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = (len_reg == '0) ? DONE : RD;
            end
            RD: begin
                o_req    = 1'b1;
                o_m_addr = src_cur;
                if (abort)
                    state_nx = IDLE;
                else if (i_gnt)
                    state_nx = WR;
            end
            WR: begin
                o_req     = 1'b1;
                o_m_we    = 1'b1;
                o_m_addr  = dst_cur;
                o_m_wdata = data_buf;
                if (abort)
                    state_nx = IDLE;
                else if (i_gnt)
                    state_nx = (cnt == LEN_W'(1)) ? DONE : RD;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // working pointers, word counter and read buffer
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            src_cur  <= '0;
            dst_cur  <= '0;
            cnt      <= '0;
            data_buf <= '0;
        end else if (state == IDLE && start) begin
            src_cur <= src_reg;
            dst_cur <= dst_reg;
            cnt     <= len_reg;
        end else if (beat && state == RD) begin
            data_buf <= i_m_rdata;
        end else if (beat && state == WR) begin
            src_cur <= src_cur + 32'd4;
            dst_cur <= dst_cur + 32'd4;
            cnt     <= cnt - LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_dma_bus_master.sv
// Directed bench for dma_bus_master with a behavioural bus slave.
// Slave read data is addr ^ 0x5A5A0000; every granted beat is logged.
module tb_dma_bus_master;

    localparam logic [31:0] B     = 32'h1000_0000;
    localparam logic [31:0] A_CTL = B + 32'h00;
    localparam logic [31:0] A_STA = B + 32'h04;
    localparam logic [31:0] A_SRC = B + 32'h08;
    localparam logic [31:0] A_DST = B + 32'h0C;
    localparam logic [31:0] A_LEN = B + 32'h10;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_cfg_we = 1'b0;
    logic [31:0] i_cfg_addr = '0;
    logic [31:0] i_cfg_wdata = '0;
    logic [31:0] o_cfg_rdata;
    logic        o_req;
    logic        i_gnt = 1'b0;
    logic        o_m_we;
    logic [31:0] o_m_addr;
    logic [31:0] o_m_wdata;
    logic [31:0] i_m_rdata;
    logic        o_irq;

    int n_cmp = 0;
    int n_bad = 0;
    int n_req = 0;

    logic        bq_we[$];
    logic [31:0] bq_addr[$];
    logic [31:0] bq_data[$];

    dma_bus_master #(.LEN_W(16)) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_addr  (i_cfg_addr),
        .i_cfg_wdata (i_cfg_wdata),
        .o_cfg_rdata (o_cfg_rdata),
        .o_req       (o_req),
        .i_gnt       (i_gnt),
        .o_m_we      (o_m_we),
        .o_m_addr    (o_m_addr),
        .o_m_wdata   (o_m_wdata),
        .i_m_rdata   (i_m_rdata),
        .o_irq       (o_irq)
    );

    always #5 i_clk = ~i_clk;

    assign i_m_rdata = o_m_addr ^ 32'h5A5A_0000;

    // log beats mid-cycle, away from the active edge
    always @(negedge i_clk) begin
        if (o_req) n_req++;
        if (o_req && i_gnt) begin
            bq_we.push_back(o_m_we);
            bq_addr.push_back(o_m_addr);
            bq_data.push_back(o_m_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg_wr(input logic [31:0] a, input logic [31:0] d);
        i_cfg_we    = 1'b1;
        i_cfg_addr  = a;
        i_cfg_wdata = d;
        tick();
        i_cfg_we    = 1'b0;
    endtask

    task automatic cfg_rd(input logic [31:0] a, output logic [31:0] d);
        i_cfg_addr = a;
        #1;
        d = o_cfg_rdata;
    endtask

    task automatic stat_is(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        cfg_rd(A_STA, d);
        chk(tag, d, exp);
    endtask

    task automatic clr_log();
        bq_we.delete();
        bq_addr.delete();
        bq_data.delete();
    endtask

    task automatic beat_is(input string tag, input int k, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        if (k >= bq_addr.size()) begin
            chk({tag, "_missing"}, 32'(bq_addr.size()), 32'(k + 1));
        end else begin
            chk({tag, "_we"}, 32'(bq_we[k]), 32'(we));
            chk({tag, "_addr"}, bq_addr[k], a);
            if (we) chk({tag, "_data"}, bq_data[k], d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;

        // reset values
        #3;
        chk("rst_req", 32'(o_req), 0);
        chk("rst_irq", 32'(o_irq), 0);
        chk("rst_maddr", o_m_addr, 0);
        chk("rst_mwdata", o_m_wdata, 0);
        chk("rst_mwe", 32'(o_m_we), 0);
        #10;
        i_rstn = 1'b1;
        tick();
        stat_is("rst_stat", 0);
        cfg_rd(A_LEN, d);
        chk("rst_len", d, 0);
        cfg_rd(B + 32'h14, d);
        chk("unmapped", d, 0);

        // 1: three-word copy with gnt held
        i_gnt = 1'b1;
        cfg_wr(A_SRC, 32'h0000_0103);
        cfg_wr(A_DST, 32'h0000_0200);
        cfg_wr(A_LEN, 32'hFFFF_0003);
        cfg_rd(A_SRC, d);
        chk("src_mask", d, 32'h100);
        cfg_rd(A_LEN, d);
        chk("len_mask", d, 32'h3);
        clr_log();
        cfg_wr(A_CTL, 32'h1);
        chk("t1_req1", 32'(o_req), 1);
        chk("t1_addr1", o_m_addr, 32'h100);
        ticks(6);
        stat_is("t1_stat_done_st", 32'h1);
        tick();
        stat_is("t1_stat_end", 32'h2);
        chk("t1_nbeats", 32'(bq_addr.size()), 6);
        beat_is("t1_b0", 0, 0, 32'h100, 0);
        beat_is("t1_b1", 1, 1, 32'h200, 32'h5A5A_0100);
        beat_is("t1_b2", 2, 0, 32'h104, 0);
        beat_is("t1_b3", 3, 1, 32'h204, 32'h5A5A_0104);
        beat_is("t1_b4", 4, 0, 32'h108, 0);
        beat_is("t1_b5", 5, 1, 32'h208, 32'h5A5A_0108);
        cfg_rd(A_SRC, d);
        chk("t1_src_kept", d, 32'h100);
        cfg_rd(A_LEN, d);
        chk("t1_len_kept", d, 32'h3);
        cfg_wr(A_STA, 32'h6);
        stat_is("t1_w1c", 0);

        // 2: irq on completion, cleared by W1C
        cfg_wr(A_CTL, 32'h2);
        cfg_rd(A_CTL, d);
        chk("t2_ctrl_rd", d, 32'h2);
        cfg_wr(A_SRC, 32'h300);
        cfg_wr(A_DST, 32'h400);
        cfg_wr(A_LEN, 32'h1);
        cfg_wr(A_CTL, 32'h3);
        ticks(2);
        chk("t2_irq_pre", 32'(o_irq), 0);
        tick();
        chk("t2_irq_on", 32'(o_irq), 1);
        cfg_wr(A_STA, 32'h2);
        chk("t2_irq_off", 32'(o_irq), 0);
        cfg_wr(A_CTL, 32'h0);

        // 3: grant stall in RD
        i_gnt = 1'b0;
        cfg_wr(A_SRC, 32'h500);
        cfg_wr(A_DST, 32'h600);
        cfg_wr(A_LEN, 32'h1);
        clr_log();
        cfg_wr(A_CTL, 32'h1);
        ticks(5);
        chk("t3_req_hold", 32'(o_req), 1);
        chk("t3_addr_hold", o_m_addr, 32'h500);
        chk("t3_we_hold", 32'(o_m_we), 0);
        i_gnt = 1'b1;
        ticks(3);
        stat_is("t3_stat", 32'h2);
        chk("t3_nbeats", 32'(bq_addr.size()), 2);
        beat_is("t3_b1", 1, 1, 32'h600, 32'h5A5A_0500);
        cfg_wr(A_STA, 32'h6);

        // 4: zero length, no bus traffic
        cfg_wr(A_LEN, 32'h0);
        n_req = 0;
        cfg_wr(A_CTL, 32'h1);
        tick();
        stat_is("t4_stat", 32'h2);
        chk("t4_noreq", 32'(n_req), 0);
        cfg_wr(A_STA, 32'h6);

        // 5: abort during second write, then restart
        cfg_wr(A_SRC, 32'h700);
        cfg_wr(A_DST, 32'h800);
        cfg_wr(A_LEN, 32'h4);
        clr_log();
        cfg_wr(A_CTL, 32'h1);
        ticks(3);
        chk("t5_in_wr", o_m_addr, 32'h804);
        cfg_wr(A_CTL, 32'h4);
        chk("t5_req_off", 32'(o_req), 0);
        stat_is("t5_stat", 32'h4);
        chk("t5_nbeats", 32'(bq_addr.size()), 4);
        cfg_wr(A_STA, 32'h4);
        cfg_wr(A_CTL, 32'h4);
        stat_is("t5_idle_abort", 0);
        cfg_wr(A_CTL, 32'h5);
        stat_is("t5_start_abort", 0);
        cfg_wr(A_LEN, 32'h1);
        clr_log();
        cfg_wr(A_CTL, 32'h1);
        ticks(3);
        stat_is("t5_restart", 32'h2);
        beat_is("t5_r0", 0, 0, 32'h700, 0);
        beat_is("t5_r1", 1, 1, 32'h800, 32'h5A5A_0700);
        cfg_wr(A_STA, 32'h6);

        // 6: address wrap, busy-ignored writes, async reset
        cfg_wr(A_SRC, 32'hFFFF_FFFC);
        cfg_wr(A_DST, 32'h900);
        cfg_wr(A_LEN, 32'h2);
        clr_log();
        cfg_wr(A_CTL, 32'h1);
        cfg_wr(A_SRC, 32'h1234);
        cfg_wr(A_CTL, 32'h1);
        chk("t6_wrap", o_m_addr, 32'h0);
        cfg_rd(A_SRC, d);
        chk("t6_src_busy", d, 32'hFFFF_FFFC);
        ticks(3);
        stat_is("t6_stat", 32'h2);
        chk("t6_nbeats", 32'(bq_addr.size()), 4);
        beat_is("t6_b1", 1, 1, 32'h900, 32'hA5A5_FFFC);
        beat_is("t6_b3", 3, 1, 32'h904, 32'h5A5A_0000);
        i_gnt = 1'b0;
        cfg_wr(A_CTL, 32'h1);
        chk("t6_rd_pre", 32'(o_req), 1);
        #2;
        i_rstn = 1'b0;
        #1;
        chk("t6_async_req", 32'(o_req), 0);
        stat_is("t6_async_stat", 0);
        cfg_rd(A_SRC, d);
        chk("t6_async_src", d, 0);
        tick();
        i_rstn = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
